// File: rtl/trng_pkg.sv
// Shared types for the TRNG key collector: FSM states, error codes and the TRNG word width.
package trng_pkg;

  localparam int TRNG_WORD_W = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_FAIL
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_RCT     = 2'b10;

endpackage

// File: rtl/trng_rct_check.sv
// Repetition-count health test: judges each checked word against the previous accepted one.
// pass/fail are combinational on the presented word; history updates only on accepted words.
module trng_rct_check
  import trng_pkg::*;
#(
  parameter int RCT_CUTOFF = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   check,
  input  logic [TRNG_WORD_W-1:0] word,
  output logic                   pass,
  output logic                   fail
);

  localparam int RC_W = $clog2(RCT_CUTOFF + 1);

  logic [TRNG_WORD_W-1:0] r_last_word;
  logic [RC_W-1:0]        r_rep_cnt;
  logic                   r_have_last;

  logic                   w_match;
  logic [RC_W-1:0]        w_rep_new;

  always_comb begin
    w_match   = r_have_last && (word == r_last_word);
    w_rep_new = w_match ? (r_rep_cnt + RC_W'(1)) : RC_W'(1);
    fail      = check && (w_rep_new >= RC_W'(RCT_CUTOFF));
    pass      = check && !fail;
  end

  // A failing word is never recorded; the collector restarts (clear) before checking again.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_last_word <= '0;
      r_rep_cnt   <= '0;
      r_have_last <= 1'b0;
    end else if (pass) begin
      r_last_word <= word;
      r_rep_cnt   <= w_rep_new;
      r_have_last <= 1'b1;
    end
  end

endmodule

// File: rtl/trng_key_collector.sv
// Requests TRNG words one at a time, health-checks them and packs KEY_WORDS words into a key.
// Two cycles per word with a one-cycle TRNG; key held with key_valid until key_ack, then zeroized.
module trng_key_collector
  import trng_pkg::*;
#(
  parameter int KEY_WORDS      = 8,
  parameter int RCT_CUTOFF     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             start,
  output logic                             trng_request,
  input  logic [TRNG_WORD_W-1:0]           trng_random,
  input  logic                             trng_ready,
  output logic [TRNG_WORD_W*KEY_WORDS-1:0] key_out,
  output logic                             key_valid,
  input  logic                             key_ack,
  output logic                             busy,
  output logic                             error,
  output logic [1:0]                       err_code
);

  localparam int WC_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t                           r_state;
  state_t                           w_state_nxt;
  logic [WC_W-1:0]                  r_word_cnt;
  logic [TO_W-1:0]                  r_to_cnt;
  logic [TRNG_WORD_W*KEY_WORDS-1:0] r_key;
  logic [1:0]                       r_err_code;

  logic w_restart;
  logic w_check;
  logic w_rct_pass;
  logic w_rct_fail;
  logic w_last_word;
  logic w_timeout;

  assign w_restart   = start && ((r_state == ST_IDLE) || (r_state == ST_FAIL));
  assign w_check     = (r_state == ST_WAIT) && trng_ready;
  assign w_last_word = (r_word_cnt == WC_W'(KEY_WORDS - 1));
  assign w_timeout   = (r_state == ST_WAIT) && !trng_ready &&
                       (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  trng_rct_check #(
    .RCT_CUTOFF (RCT_CUTOFF)
  ) u_rct (
    .clk   (clk),
    .rst   (rst),
    .clear (w_restart),
    .check (w_check),
    .word  (trng_random),
    .pass  (w_rct_pass),
    .fail  (w_rct_fail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start) w_state_nxt = ST_REQ;
      ST_REQ:  w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (w_check) begin
          if (w_rct_fail)       w_state_nxt = ST_FAIL;
          else if (w_last_word) w_state_nxt = ST_DONE;
          else                  w_state_nxt = ST_REQ;
        end else if (w_timeout) begin
          w_state_nxt = ST_FAIL;
        end
      end
      ST_DONE: if (key_ack) w_state_nxt = ST_IDLE;
      ST_FAIL: if (start) w_state_nxt = ST_REQ;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs decode the state register directly, so each is a clean registered level.
  always_comb begin
    trng_request = (r_state == ST_REQ);
    busy         = (r_state == ST_REQ) || (r_state == ST_WAIT) || (r_state == ST_DONE);
    key_valid    = (r_state == ST_DONE);
    error        = (r_state == ST_FAIL);
    err_code     = r_err_code;
    key_out      = r_key;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_word_cnt <= '0;
      r_to_cnt   <= '0;
      r_key      <= '0;
      r_err_code <= ERR_NONE;
    end else begin
      if (w_restart) begin
        r_word_cnt <= '0;
        r_err_code <= ERR_NONE;
      end

      if (r_state == ST_REQ) begin
        r_to_cnt <= '0;
      end else if ((r_state == ST_WAIT) && !trng_ready && !w_timeout) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end

      if (w_rct_pass) begin
        for (int i = 0; i < KEY_WORDS; i++) begin
          if (r_word_cnt == WC_W'(i)) begin
            r_key[i*TRNG_WORD_W +: TRNG_WORD_W] <= trng_random;
          end
        end
        if (!w_last_word) begin
          r_word_cnt <= r_word_cnt + WC_W'(1);
        end
      end

      // Any partial key is wiped the moment collection fails.
      if (w_rct_fail) begin
        r_err_code <= ERR_RCT;
        r_key      <= '0;
      end
      if (w_timeout) begin
        r_err_code <= ERR_TIMEOUT;
        r_key      <= '0;
      end

      if ((r_state == ST_DONE) && key_ack) begin
        r_key <= '0;
      end
    end
  end

endmodule
